// File: rtl/snn_decode_pkg.sv
// Shared definitions for the spike rate decoder: FSM encoding and index-width helper.
// Pure declarations; no latency, no flow control.
package snn_decode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2 that never returns less than 1, so a single lane still gets an index bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/spike_lane_counter.sv
// Per-lane saturating spike counter with a sticky saturation flag.
// Counts on the edge where en and spike are both high; clear has priority; no backpressure.
module spike_lane_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   spike,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   sat
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en && spike) begin
            // An increment attempted at full scale flags overflow instead of wrapping.
            if (count == '1) begin
                sat <= 1'b1;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per lane over a programmed window, then picks the busiest lane (ties -> lowest index).
// done appears window_len + NUM_SPIKES + 1 edges after start acceptance; start is dropped unless IDLE.
module spike_rate_decoder
    import snn_decode_pkg::*;
#(
    parameter int NUM_SPIKES   = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int IDX_WIDTH    = clog2_min1(NUM_SPIKES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WINDOW_WIDTH-1:0]           window_len,
    input  logic [NUM_SPIKES-1:0]             spike_in,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_SPIKES*COUNT_WIDTH-1:0] counts,
    output logic [IDX_WIDTH-1:0]              winner_idx,
    output logic                              winner_valid,
    output logic                              overflow
);

    localparam logic [IDX_WIDTH-1:0]    LAST_IDX = IDX_WIDTH'(NUM_SPIKES - 1);
    localparam logic [IDX_WIDTH-1:0]    ONE_IDX  = IDX_WIDTH'(1);
    localparam logic [WINDOW_WIDTH-1:0] ONE_WIN  = WINDOW_WIDTH'(1);

    state_t state, state_nxt;

    logic [WINDOW_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0]  lane_cnt [NUM_SPIKES];
    logic [NUM_SPIKES-1:0]   lane_sat;

    logic [IDX_WIDTH-1:0]    scan_rd_idx;
    logic                    scan_rd_done;
    logic                    cand_vld;
    logic [COUNT_WIDTH-1:0]  cand_cnt;
    logic [IDX_WIDTH-1:0]    cand_idx;
    logic [COUNT_WIDTH-1:0]  best_cnt;
    logic [IDX_WIDTH-1:0]    best_idx;

    logic start_accept;
    logic scan_enter;
    logic scan_last;
    logic cand_better;

    assign start_accept = (state == IDLE) && start;
    assign scan_enter   = (start_accept && (window_len == '0)) ||
                          ((state == COUNT) && (remaining == ONE_WIN));
    assign cand_better  = cand_cnt > best_cnt;
    assign scan_last    = (state == SCAN) && cand_vld && (cand_idx == LAST_IDX);

    generate
        for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_lane
            spike_lane_counter #(
                .COUNT_WIDTH (COUNT_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clear (start_accept),
                .en    (state == COUNT),
                .spike (spike_in[i]),
                .count (lane_cnt[i]),
                .sat   (lane_sat[i])
            );
            assign counts[i*COUNT_WIDTH +: COUNT_WIDTH] = lane_cnt[i];
        end
    endgenerate

    assign overflow = |lane_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (window_len != '0) ? COUNT : SCAN;
                end
            end
            COUNT: begin
                busy = 1'b1;
                if (remaining == ONE_WIN) state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan is a two-stage pipe: read one lane into cand, compare cand against best next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= '0;
            scan_rd_idx  <= '0;
            scan_rd_done <= 1'b0;
            cand_vld     <= 1'b0;
            cand_cnt     <= '0;
            cand_idx     <= '0;
            best_cnt     <= '0;
            best_idx     <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
        end else begin
            if (start_accept) begin
                remaining <= window_len;
            end else if (state == COUNT) begin
                remaining <= remaining - ONE_WIN;
            end

            if (scan_enter) begin
                scan_rd_idx  <= '0;
                scan_rd_done <= 1'b0;
                cand_vld     <= 1'b0;
                best_cnt     <= '0;
                best_idx     <= '0;
            end else if (state == SCAN) begin
                if (!scan_rd_done) begin
                    cand_cnt     <= lane_cnt[scan_rd_idx];
                    cand_idx     <= scan_rd_idx;
                    cand_vld     <= 1'b1;
                    scan_rd_idx  <= scan_rd_idx + ONE_IDX;
                    scan_rd_done <= (scan_rd_idx == LAST_IDX);
                end else begin
                    cand_vld <= 1'b0;
                end

                if (cand_vld && cand_better) begin
                    best_cnt <= cand_cnt;
                    best_idx <= cand_idx;
                end

                if (scan_last) begin
                    winner_idx   <= cand_better ? cand_idx : best_idx;
                    winner_valid <= cand_better || (best_cnt != '0);
                end
            end
        end
    end

endmodule
